systolic_result_drain: RTL

- Sits directly downstream of systolic_array_4x4.
- Snapshots the 16 × 32-bit accumulator results when the array signals completion, then requantizes each result to OUT_W bits.
- Streams the results out row-major over a valid/ready interface, feeding the next layer's input buffer.
- Frees the array for the next computation as soon as the snapshot is taken.

---
 rtl/systolic_result_drain.sv | 128 ++++++++++++
 1 files changed

// File: rtl/systolic_result_drain.sv
// systolic_result_drain: snapshots 4x4 accumulator results, requantizes them and streams them row-major
module systolic_result_drain #(
    parameter int ACC_W   = 32,
    parameter int OUT_W   = 16,
    parameter int SHIFT_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                computation_done,
    input  logic [16*ACC_W-1:0] results_flat,
    input  logic [SHIFT_W-1:0]  shift_amt,
    output logic [OUT_W-1:0]    out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [1:0]          out_row,
    output logic [1:0]          out_col,
    output logic                out_last,
    output logic                busy,
    output logic [4:0]          sat_count,
    output logic                drop_err
);
    localparam int RW = ACC_W + 1;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t             r_state, w_state_next;
    logic [ACC_W-1:0]   r_snap [16];
    logic [SHIFT_W-1:0] r_shift;
    logic [3:0]         r_idx;
    logic [OUT_W-1:0]   r_data;
    logic [4:0]         r_sat;
    logic               r_drop, r_prev_done;
    logic               w_capture, w_take, w_drop, w_step, w_end;
    logic [4:0]         w_sat_cnt;
    logic [ACC_W:0]     w_first_y, w_next_y;

    // Half-up rounding right shift in ACC_W+1 bits so the carry out of 0xFFFFFFFF survives
    function automatic logic [ACC_W:0] rnd(input logic [ACC_W-1:0] x, input logic [SHIFT_W-1:0] s);
        logic [ACC_W:0] sum;
        sum = {1'b0, x} + (RW'(1) << (s - SHIFT_W'(1)));
        return (s == '0) ? {1'b0, x} : sum >> s;
    endfunction

    function automatic logic is_sat(input logic [ACC_W:0] y);
        return |y[ACC_W:OUT_W];
    endfunction

    function automatic logic [OUT_W-1:0] clamp(input logic [ACC_W:0] y);
        return is_sat(y) ? '1 : y[OUT_W-1:0];
    endfunction

    assign w_capture = computation_done && !r_prev_done;
    assign w_first_y = rnd(results_flat[ACC_W-1:0], shift_amt);
    assign w_next_y  = rnd(r_snap[r_idx + 4'd1], r_shift);
    assign out_valid = (r_state == STREAM);
    assign busy      = (r_state == STREAM);
    assign out_data  = r_data;
    assign out_row   = r_idx[3:2];
    assign out_col   = r_idx[1:0];
    assign out_last  = out_valid && (r_idx == 4'd15);
    assign sat_count = r_sat;
    assign drop_err  = r_drop;

    // Count saturating elements of the incoming snapshot so the total is ready at capture
    always_comb begin
        w_sat_cnt = '0;
        for (int i = 0; i < 16; i++)
            w_sat_cnt = w_sat_cnt + 5'(is_sat(rnd(results_flat[ACC_W*i +: ACC_W], shift_amt)));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // Next state; a capture on the final handshake reloads without leaving STREAM
    always_comb begin
        w_state_next = r_state;
        w_take       = 1'b0;
        w_drop       = 1'b0;
        w_step       = 1'b0;
        w_end        = 1'b0;
        if (r_state == IDLE) begin
            w_take = w_capture;
            if (w_capture) w_state_next = STREAM;
        end else if (out_ready && r_idx == 4'd15) begin
            w_take = w_capture;
            w_end  = !w_capture;
            if (!w_capture) w_state_next = IDLE;
        end else begin
            w_step = out_ready;
            w_drop = w_capture;
        end
    end

    // Snapshot storage needs no reset; it is only read while streaming
    always_ff @(posedge clk) begin
        if (w_take) begin
            for (int i = 0; i < 16; i++) r_snap[i] <= results_flat[ACC_W*i +: ACC_W];
            r_shift <= shift_amt;
        end
    end

    // Element index, registered output data, saturation count and sticky drop flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_done <= 1'b0;
            r_drop      <= 1'b0;
            r_idx       <= '0;
            r_data      <= '0;
            r_sat       <= '0;
        end else begin
            r_prev_done <= computation_done;
            r_drop      <= r_drop | w_drop;
            if (w_take) begin
                r_idx  <= '0;
                r_data <= clamp(w_first_y);
                r_sat  <= w_sat_cnt;
            end else if (w_step) begin
                r_idx  <= r_idx + 4'd1;
                r_data <= clamp(w_next_y);
            end else if (w_end) begin
                r_idx  <= '0;
            end
        end
    end
endmodule
